pf_ddr4_pll_phase_ctrl: RTL and testbench
=========================================

// Module: pf_ddr4_pll_phase_ctrl
// PURPOSE
//  Sequencer directly upstream of the DDR4 PLL clock-conditioning wrapper. Drives its dynamic
//  phase-adjust pins (PHASE_OUTx_SEL, PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N) and
//  PLL_POWERDOWN_N, and monitors PLL_LOCK. Converts one request "move output X by N steps in
//  direction D" into correctly timed rotate pulses followed by a load strobe.
// PARAMETERS
//  PD_CYC       16    cycles PLL_POWERDOWN_N held low after reset or lock timeout
//  LOCK_TIMEOUT 4096  cycles to wait for synced lock before ERR and power cycle
//  SETUP_CYC    2     cycles SEL/DIRECTION are stable before the first rotate pulse
//  ROT_HI_CYC   2     PHASE_ROTATE high time per step
//  ROT_LO_CYC   4     PHASE_ROTATE low time per step
//  LOAD_CYC     2     LOAD_PHASE_N low time after the last step
// PORTS
//  CLK              in   1  system clock; all logic on rising edge
//  RESET            in   1  synchronous, active-high reset
//  REQ_VALID        in   1  phase-move request valid
//  REQ_READY        out  1  controller idle and locked; request accepted on VALID&READY
//  REQ_SEL          in   2  0=OUT0, 1=OUT2, 2=OUT3, 3=illegal
//  REQ_DIR          in   1  1=advance, 0=retard (driven onto PHASE_DIRECTION)
//  REQ_STEPS        in   8  rotate steps, 0..255
//  DONE             out  1  1-cycle pulse when a request completes
//  ERR              out  1  1-cycle pulse: illegal SEL, lock lost mid-move, or lock timeout
//  LOCKED           out  1  synchronised PLL lock status
//  PLL_LOCK         in   1  from PLL, asynchronous; 2-flop synchronised internally
//  PLL_POWERDOWN_N  out  1  to PLL
//  PHASE_OUT0_SEL / PHASE_OUT2_SEL / PHASE_OUT3_SEL  out 1 each  one-hot output select
//  PHASE_DIRECTION  out  1  to PLL
//  PHASE_ROTATE     out  1  to PLL
//  LOAD_PHASE_N     out  1  to PLL, active low
// BEHAVIOUR
//  - Reset values: PLL_POWERDOWN_N=0, all SEL=0, DIRECTION=0, ROTATE=0, LOAD_PHASE_N=1,
//    REQ_READY=0, DONE=0, ERR=0, LOCKED=0. All outputs are registered.
//  - FSM: PWRDN -> WAIT_LOCK -> IDLE -> SETUP -> ROT_HI <-> ROT_LO -> LOAD -> IDLE.
//  - PWRDN: POWERDOWN_N=0 for PD_CYC cycles, then 1; enter WAIT_LOCK.
//  - WAIT_LOCK: go to IDLE when LOCKED=1. After LOCK_TIMEOUT cycles: ERR pulse, back to PWRDN.
//  - IDLE: REQ_READY=1 only here and only with LOCKED=1.
//  - Accept, SEL=3: ERR pulse next cycle, no pin activity, stay in IDLE.
//  - Accept, STEPS=0: DONE pulse next cycle, no pin activity.
//  - Accept, otherwise: latch SEL, DIR and STEPS; drive one-hot SEL and DIRECTION through LOAD.
//  - SETUP lasts SETUP_CYC cycles.
//  - Each step: ROTATE=1 for ROT_HI_CYC cycles, then 0 for ROT_LO_CYC cycles; the step
//    counter decrements at the end of ROT_LO.
//  - After the last step: LOAD_PHASE_N=0 for LOAD_CYC cycles.
//  - Then DONE pulses, SEL and DIRECTION clear, and the FSM returns to IDLE.
//  - Latency: DONE rises SETUP_CYC + N*(ROT_HI_CYC+ROT_LO_CYC) + LOAD_CYC + 1 cycles after
//    the accept edge. Defaults with N=3: 23 cycles.
//  - Lock loss (LOCKED 1->0) in SETUP, ROT_HI, ROT_LO or LOAD: next cycle ROTATE=0,
//    LOAD_PHASE_N=1, SEL=0, ERR pulse, no DONE, enter WAIT_LOCK. The partial move is not retried.
//  - Lock loss in IDLE: REQ_READY drops in the same cycle as LOCKED; enter WAIT_LOCK, no ERR.
//  - RESET mid-move: all outputs return to reset values at the next edge; any pending DONE is
//    lost.
//  - Counters are sized with $clog2 of their parameter; no wrap occurs inside a legal move.
// CONFIGURATION
//  - PHASE_POS_TRACK_EN defined:
//    - Adds outputs PHASE_POS_OUT0, PHASE_POS_OUT2 and PHASE_POS_OUT3 (out, 8 bits each).
//    - Each is a signed two's-complement net step count per output: +1 per advance step,
//      -1 per retard step, updated at the end of each ROT_LO.
//    - Counts wrap modulo 256.
//    - Cleared to 0 on RESET and on every PWRDN entry.
//    - Not rolled back on an aborted move.
//  - PHASE_POS_TRACK_EN undefined: the ports and accumulators are absent. All other behaviour
//    is identical.
// TESTING
//  - RESET, then PLL_LOCK=1 at cycle 40 -> POWERDOWN_N rises after 16 cycles; REQ_READY=1
//    2-3 cycles after lock.
//  - SEL=0, DIR=1, STEPS=3 -> PHASE_OUT0_SEL high; 3 ROTATE pulses of 2 high/4 low; LOAD_PHASE_N
//    low 2 cycles; DONE at accept+23; PHASE_POS_OUT0=+3 when tracking is enabled.
//  - SEL=3 -> ERR 1 cycle, no pin toggles. STEPS=0 -> DONE next cycle, no pin toggles.
//  - PLL_LOCK dropped during the 2nd ROT_HI of a 5-step move -> ROTATE low within 3 cycles;
//    ERR pulse; no DONE; REQ_READY returns after relock.
//  - PLL_LOCK held 0 -> ERR at LOCK_TIMEOUT and POWERDOWN_N re-pulsed low for 16 cycles.
//  - RESET asserted mid-LOAD -> next edge: LOAD_PHASE_N=1, POWERDOWN_N=0, DONE never pulses.

Source files
------------

// File: rtl/pf_ddr4_pll_phase_ctrl.sv
// rtl/pf_ddr4_pll_phase_ctrl.sv - DDR4 PLL dynamic phase-adjust sequencer
//
// Turns one "move output X by N steps in direction D" request into timed
// PHASE_ROTATE pulses followed by a LOAD_PHASE_N strobe. It also sequences
// PLL power-down and lock acquisition.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only when idle and locked)
//   req_sel, req_dir, req_steps output select (3 illegal), direction, step count
//   done, err                   single-cycle completion / error pulses
//   locked                      synchronised PLL lock status
//   pll_lock                    asynchronous lock input from the PLL
//   pll_powerdown_n             PLL power-down control (active low)
//   phase_out{0,2,3}_sel        one-hot output select to the PLL
//   phase_direction             1 = advance, 0 = retard
//   phase_rotate                one pulse per phase step
//   load_phase_n                active-low phase load strobe
//   phase_pos_out{0,2,3}        net signed step count per output, present only
//                               when PHASE_POS_TRACK_EN is defined
//
// Build option: PHASE_POS_TRACK_EN

module pf_ddr4_pll_phase_ctrl #(
    parameter int PD_CYC       = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SETUP_CYC    = 2,
    parameter int ROT_HI_CYC   = 2,
    parameter int ROT_LO_CYC   = 4,
    parameter int LOAD_CYC     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    output logic       done,
    output logic       err,
    output logic       locked,
    input  logic       pll_lock,
    output logic       pll_powerdown_n,
    output logic       phase_out0_sel,
    output logic       phase_out2_sel,
    output logic       phase_out3_sel,
    output logic       phase_direction,
    output logic       phase_rotate,
    output logic       load_phase_n
`ifdef PHASE_POS_TRACK_EN
    ,
    output logic [7:0] phase_pos_out0,
    output logic [7:0] phase_pos_out2,
    output logic [7:0] phase_pos_out3
`endif
);

    // One shared phase counter, wide enough for the longest timed phase.
    localparam int MAX_AB = (PD_CYC > LOCK_TIMEOUT) ? PD_CYC : LOCK_TIMEOUT;
    localparam int MAX_CD = (SETUP_CYC > LOAD_CYC) ? SETUP_CYC : LOAD_CYC;
    localparam int MAX_EF = (ROT_HI_CYC > ROT_LO_CYC) ? ROT_HI_CYC : ROT_LO_CYC;
    localparam int MAX_GH = (MAX_CD > MAX_EF) ? MAX_CD : MAX_EF;
    localparam int MAXC   = (MAX_AB > MAX_GH) ? MAX_AB : MAX_GH;
    localparam int CW     = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] PD_LAST    = CW'(PD_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HI_LAST    = CW'(ROT_HI_CYC - 1);
    localparam logic [CW-1:0] LO_LAST    = CW'(ROT_LO_CYC - 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRDN,
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_ROT_HI,
        S_ROT_LO,
        S_LOAD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    steps_q, steps_d;
    logic [1:0]    sel_lat_q, sel_lat_d;
    logic          dir_lat_q, dir_lat_d;
    logic          sync1_q, sync1_d;
    logic          locked_q, locked_d;
    logic          ready_q, ready_d;
    logic          done_pend_q, done_pend_d;
    logic          err_pend_q, err_pend_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pd_n_q, pd_n_d;
    logic [2:0]    sel_oh_q, sel_oh_d;
    logic          dir_q, dir_d;
    logic          rot_q, rot_d;
    logic          load_n_q, load_n_d;
`ifdef PHASE_POS_TRACK_EN
    logic [7:0]    pos0_q, pos0_d;
    logic [7:0]    pos2_q, pos2_d;
    logic [7:0]    pos3_q, pos3_d;
    logic [7:0]    pos_inc;
`endif

    logic accept;
    logic in_move;
    logic abort;
    logic move_drive;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        steps_d     = steps_q;
        sel_lat_d   = sel_lat_q;
        dir_lat_d   = dir_lat_q;
        done_pend_d = 1'b0;
        err_pend_d  = 1'b0;
        // Completion and illegal-request events are reported one cycle later.
        done_d      = done_pend_q;
        err_d       = err_pend_q;
`ifdef PHASE_POS_TRACK_EN
        pos0_d  = pos0_q;
        pos2_d  = pos2_q;
        pos3_d  = pos3_q;
        pos_inc = dir_lat_q ? 8'd1 : 8'hFF;
`endif

        accept  = req_valid && ready_q;
        in_move = (state_q == S_SETUP) || (state_q == S_ROT_HI) ||
                  (state_q == S_ROT_LO) || (state_q == S_LOAD);
        abort   = in_move && !locked_q;

        if (abort) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                S_PWRDN: begin
                    if (cnt_q == PD_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = S_PWRDN;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!locked_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (accept) begin
                        if (req_sel == 2'd3) begin
                            err_pend_d = 1'b1;
                        end else if (req_steps == 8'd0) begin
                            done_pend_d = 1'b1;
                        end else begin
                            state_d   = S_SETUP;
                            cnt_d     = '0;
                            sel_lat_d = req_sel;
                            dir_lat_d = req_dir;
                            steps_d   = req_steps;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_d = S_ROT_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ROT_HI: begin
                    if (cnt_q == HI_LAST) begin
                        state_d = S_ROT_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ROT_LO: begin
                    if (cnt_q == LO_LAST) begin
                        // A step is counted as taken only at the end of its low time.
                        steps_d = steps_q - 1'b1;
                        cnt_d   = '0;
                        state_d = (steps_q == 8'd1) ? S_LOAD : S_ROT_HI;
`ifdef PHASE_POS_TRACK_EN
                        case (sel_lat_q)
                            2'd0:    pos0_d = pos0_q + pos_inc;
                            2'd1:    pos2_d = pos2_q + pos_inc;
                            default: pos3_d = pos3_q + pos_inc;
                        endcase
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        done_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_PWRDN;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef PHASE_POS_TRACK_EN
        if ((state_d == S_PWRDN) && (state_q != S_PWRDN)) begin
            pos0_d = 8'd0;
            pos2_d = 8'd0;
            pos3_d = 8'd0;
        end
`endif

        sync1_d  = pll_lock;
        locked_d = sync1_q;
        // Ready tracks the same synchroniser stage as locked so both drop together.
        ready_d  = (state_d == S_IDLE) && sync1_q;
        pd_n_d   = (state_d != S_PWRDN);

        // Pin outputs follow the current state one cycle behind, which gives
        // the select/direction lines their lead over the first rotate pulse.
        move_drive = in_move && !abort;
        sel_oh_d   = 3'b000;
        if (move_drive) begin
            case (sel_lat_q)
                2'd0:    sel_oh_d = 3'b001;
                2'd1:    sel_oh_d = 3'b010;
                default: sel_oh_d = 3'b100;
            endcase
        end
        dir_d    = move_drive && dir_lat_q;
        rot_d    = (state_q == S_ROT_HI) && !abort;
        load_n_d = !((state_q == S_LOAD) && !abort);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PWRDN;
            cnt_q       <= '0;
            steps_q     <= 8'd0;
            sel_lat_q   <= 2'd0;
            dir_lat_q   <= 1'b0;
            sync1_q     <= 1'b0;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pd_n_q      <= 1'b0;
            sel_oh_q    <= 3'b000;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            load_n_q    <= 1'b1;
`ifdef PHASE_POS_TRACK_EN
            pos0_q      <= 8'd0;
            pos2_q      <= 8'd0;
            pos3_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            steps_q     <= steps_d;
            sel_lat_q   <= sel_lat_d;
            dir_lat_q   <= dir_lat_d;
            sync1_q     <= sync1_d;
            locked_q    <= locked_d;
            ready_q     <= ready_d;
            done_pend_q <= done_pend_d;
            err_pend_q  <= err_pend_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pd_n_q      <= pd_n_d;
            sel_oh_q    <= sel_oh_d;
            dir_q       <= dir_d;
            rot_q       <= rot_d;
            load_n_q    <= load_n_d;
`ifdef PHASE_POS_TRACK_EN
            pos0_q      <= pos0_d;
            pos2_q      <= pos2_d;
            pos3_q      <= pos3_d;
`endif
        end
    end

    assign req_ready       = ready_q;
    assign done            = done_q;
    assign err             = err_q;
    assign locked          = locked_q;
    assign pll_powerdown_n = pd_n_q;
    assign phase_out0_sel  = sel_oh_q[0];
    assign phase_out2_sel  = sel_oh_q[1];
    assign phase_out3_sel  = sel_oh_q[2];
    assign phase_direction = dir_q;
    assign phase_rotate    = rot_q;
    assign load_phase_n    = load_n_q;
`ifdef PHASE_POS_TRACK_EN
    assign phase_pos_out0  = pos0_q;
    assign phase_pos_out2  = pos2_q;
    assign phase_pos_out3  = pos3_q;
`endif

endmodule

// File: tb/tb_pf_ddr4_pll_phase_ctrl.sv
// tb/tb_pf_ddr4_pll_phase_ctrl.sv - self-checking bench for pf_ddr4_pll_phase_ctrl

module tb_pf_ddr4_pll_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       done;
    logic       err;
    logic       locked;
    logic       pll_lock;
    logic       pll_powerdown_n;
    logic       phase_out0_sel;
    logic       phase_out2_sel;
    logic       phase_out3_sel;
    logic       phase_direction;
    logic       phase_rotate;
    logic       load_phase_n;
`ifdef PHASE_POS_TRACK_EN
    logic [7:0] phase_pos_out0;
    logic [7:0] phase_pos_out2;
    logic [7:0] phase_pos_out3;
`endif

    always #5 clk = ~clk;

    pf_ddr4_pll_phase_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_sel         (req_sel),
        .req_dir         (req_dir),
        .req_steps       (req_steps),
        .done            (done),
        .err             (err),
        .locked          (locked),
        .pll_lock        (pll_lock),
        .pll_powerdown_n (pll_powerdown_n),
        .phase_out0_sel  (phase_out0_sel),
        .phase_out2_sel  (phase_out2_sel),
        .phase_out3_sel  (phase_out3_sel),
        .phase_direction (phase_direction),
        .phase_rotate    (phase_rotate),
        .load_phase_n    (load_phase_n)
`ifdef PHASE_POS_TRACK_EN
        ,
        .phase_pos_out0  (phase_pos_out0),
        .phase_pos_out2  (phase_pos_out2),
        .phase_pos_out3  (phase_pos_out3)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pos_m [3];

    typedef struct {
        int sel;
        int dir;
        int steps;
        int lat;
        int exp_done;
        int exp_err;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: accept-to-DONE distance from the move timing rules.
    function automatic int model_lat(input int sel, input int steps);
        if (sel == 3 || steps == 0) return 1;
        return 2 + steps * (2 + 4) + 2 + 1;
    endfunction

    function automatic int onehot(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
    endfunction

    task automatic check_pos(input string name);
`ifdef PHASE_POS_TRACK_EN
        check({name, "_pos0"}, int'(phase_pos_out0), pos_m[0] & 255);
        check({name, "_pos2"}, int'(phase_pos_out2), pos_m[1] & 255);
        check({name, "_pos3"}, int'(phase_pos_out3), pos_m[2] & 255);
`endif
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!req_ready && w < 300) begin
            tick();
            w++;
        end
        check({name, "_ready"}, int'(req_ready), 1);
    endtask

    task automatic issue(input int sel, input int dir, input int steps);
        req_valid = 1'b1;
        req_sel   = 2'(sel);
        req_dir   = 1'(dir);
        req_steps = 8'(steps);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_req(input string name, input int sel, input int dir, input int steps,
                           input int lat, input int exp_done, input int exp_err);
        int done_k, err_k, ndone, nerr, pulses, hi, lo, match, bad, prev_rot, sv, is_move;
        done_k = 0; err_k = 0; ndone = 0; nerr = 0; pulses = 0; hi = 0; lo = 0;
        match = 0; bad = 0; prev_rot = 0;
        is_move = (exp_done != 0 && steps > 0) ? 1 : 0;
        wait_ready(name);
        issue(sel, dir, steps);
        for (int k = 1; k <= lat + 4; k++) begin
            tick();
            if (done) begin ndone++; if (done_k == 0) done_k = k; end
            if (err) begin nerr++; if (err_k == 0) err_k = k; end
            if (phase_rotate && prev_rot == 0) pulses++;
            if (phase_rotate) hi++;
            prev_rot = int'(phase_rotate);
            if (!load_phase_n) lo++;
            sv = int'({phase_out3_sel, phase_out2_sel, phase_out0_sel});
            if (sv != 0 && sv == onehot(sel) && int'(phase_direction) == dir) match++;
            else if (sv != 0) bad++;
        end
        check({name, "_done_at"}, done_k, exp_done ? lat : 0);
        check({name, "_done_cnt"}, ndone, exp_done ? 1 : 0);
        check({name, "_err_at"}, err_k, exp_err ? lat : 0);
        check({name, "_err_cnt"}, nerr, exp_err ? 1 : 0);
        check({name, "_rot_pulses"}, pulses, is_move ? steps : 0);
        check({name, "_rot_hi"}, hi, is_move ? 2 * steps : 0);
        check({name, "_load_lo"}, lo, is_move ? 2 : 0);
        check({name, "_sel_cyc"}, match, is_move ? lat - 1 : 0);
        check({name, "_sel_bad"}, bad, 0);
        if (is_move) pos_m[sel] += dir ? steps : -steps;
        check_pos(name);
    endtask

    initial begin
        int rise_k, rdy_k, rlow_k, err_k, nerr, ndone, pulses, prev_rot;
        int lfall_k, rfall_k, pd_low, sel, dir, steps;

        vt[0] = '{0, 1, 3,   23,   1, 0};
        vt[1] = '{1, 0, 1,   11,   1, 0};
        vt[2] = '{2, 1, 2,   17,   1, 0};
        vt[3] = '{3, 1, 5,   1,    0, 1};
        vt[4] = '{0, 0, 0,   1,    1, 0};
        vt[5] = '{3, 0, 0,   1,    0, 1};
        vt[6] = '{1, 1, 4,   29,   1, 0};
        vt[7] = '{2, 0, 255, 1535, 1, 0};
        for (int i = 0; i < 3; i++) pos_m[i] = 0;

        reset = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_dir = 1'b0;
        req_steps = 8'd0; pll_lock = 1'b0;
        tick(); tick(); tick();
        check("rst_pd_n", int'(pll_powerdown_n), 0);
        check("rst_sel", int'({phase_out3_sel, phase_out2_sel, phase_out0_sel}), 0);
        check("rst_dir", int'(phase_direction), 0);
        check("rst_rot", int'(phase_rotate), 0);
        check("rst_load_n", int'(load_phase_n), 1);
        check("rst_ready", int'(req_ready), 0);
        check("rst_done_err", int'({done, err}), 0);
        check("rst_locked", int'(locked), 0);

        // Bring-up: power-down released 16 cycles after reset, lock at cycle 40.
        reset = 1'b0;
        rise_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (pll_powerdown_n && rise_k == 0) rise_k = k;
        end
        check("pd_rise", rise_k, 16);
        pll_lock = 1'b1;
        rdy_k = 0;
        for (int k = 1; k <= 10 && rdy_k == 0; k++) begin
            tick();
            if (req_ready) rdy_k = k;
        end
        check("ready_after_lock_ok", (rdy_k >= 2 && rdy_k <= 3) ? 1 : 0, 1);
        check("locked_up", int'(locked), 1);

        for (int i = 0; i < 8; i++)
            run_req($sformatf("vec%0d", i), vt[i].sel, vt[i].dir, vt[i].steps,
                    vt[i].lat, vt[i].exp_done, vt[i].exp_err);

        for (int i = 0; i < 12; i++) begin
            sel   = int'($urandom_range(0, 3));
            dir   = int'($urandom_range(0, 1));
            steps = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 10));
            run_req($sformatf("rnd%0d", i), sel, dir, steps, model_lat(sel, steps),
                    (sel != 3) ? 1 : 0, (sel == 3) ? 1 : 0);
        end

        // Lock lost during the 2nd rotate-high of a 5-step advance move on OUT2.
        wait_ready("ll");
        issue(1, 1, 5);
        for (int k = 1; k <= 9; k++) tick();
        check("ll_rot_before", int'(phase_rotate), 1);
        pll_lock = 1'b0;
        rlow_k = 0; err_k = 0; nerr = 0; ndone = 0; pulses = 0; prev_rot = 1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (!phase_rotate && rlow_k == 0) rlow_k = j;
            if (phase_rotate && prev_rot == 0) pulses++;
            prev_rot = int'(phase_rotate);
            if (err) begin nerr++; if (err_k == 0) err_k = j; end
            if (done) ndone++;
        end
        check("ll_rot_low_ok", (rlow_k >= 1 && rlow_k <= 3) ? 1 : 0, 1);
        check("ll_err_at", err_k, 3);
        check("ll_err_cnt", nerr, 1);
        check("ll_no_done", ndone, 0);
        check("ll_no_more_rot", pulses, 0);
        check("ll_sel_clear", int'({phase_out3_sel, phase_out2_sel, phase_out0_sel}), 0);
        check("ll_load_n", int'(load_phase_n), 1);
        check("ll_ready", int'(req_ready), 0);
        pos_m[1] += 1;
        check_pos("ll");
        pll_lock = 1'b1;
        wait_ready("ll_relock");

        // Reset asserted while LOAD_PHASE_N is low.
        issue(2, 0, 1);
        for (int k = 1; k <= 9; k++) tick();
        check("rl_load_low", int'(load_phase_n), 0);
        reset = 1'b1;
        tick();
        check("rl_load_n", int'(load_phase_n), 1);
        check("rl_pd_n", int'(pll_powerdown_n), 0);
        check("rl_sel", int'({phase_out3_sel, phase_out2_sel, phase_out0_sel}), 0);
        check("rl_ready", int'(req_ready), 0);
        tick(); tick();
        reset = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done) ndone++;
        end
        check("rl_no_done", ndone, 0);
        for (int i = 0; i < 3; i++) pos_m[i] = 0;
        check_pos("rl");
        wait_ready("rl_up");
        run_req("post_rst", 0, 1, 2, 17, 1, 0);

        // Lock lost in idle and never returns: timeout, then power cycle.
        pll_lock = 1'b0;
        lfall_k = 0; rfall_k = 0; err_k = 0; nerr = 0; pd_low = 0;
        for (int k = 1; k <= 4130; k++) begin
            tick();
            if (!locked && lfall_k == 0) lfall_k = k;
            if (!req_ready && rfall_k == 0) rfall_k = k;
            if (err) begin nerr++; if (err_k == 0) err_k = k; end
            if (!pll_powerdown_n) pd_low++;
        end
        check("to_ready_with_locked", rfall_k, lfall_k);
        check("to_locked_fall", lfall_k, 2);
        check("to_err_at", err_k, 4099);
        check("to_err_cnt", nerr, 1);
        check("to_pd_low", pd_low, 16);
        for (int i = 0; i < 3; i++) pos_m[i] = 0;
        check_pos("to");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
